// File: rtl/hazard_scoreboard.sv
// Register-file hazard scoreboard: tracks in-flight writers, raises the ID data stall and picks bypass stages.
// Optional stall performance counter is built only when HAZ_PERF_CNT_EN is defined.
module hazard_scoreboard #(
  parameter  int NSTAGE = 4,
  parameter  int LAT_W  = 3,
  localparam int AGE_W  = $clog2(NSTAGE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             issue,
  input  logic             issue_wr,
  input  logic [4:0]       issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             pipe_hold,
  input  logic             flush,
  input  logic [AGE_W-1:0] flush_age,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             data_stall,
  output logic [AGE_W-1:0] rs_fwd,
  output logic [AGE_W-1:0] rt_fwd,
  output logic [31:0]      stall_cnt
);

  logic [31:0]      r_pend;
  logic [LAT_W-1:0] r_cnt [32];
  logic [AGE_W-1:0] r_age [32];

  logic w_issue_load;
  logic w_rs_wait;
  logic w_rt_wait;
  logic w_rs_ready;
  logic w_rt_ready;

  // A flushed or frozen issue never reaches EX, so it must not be recorded.
  assign w_issue_load = issue & issue_wr & (issue_rd != 5'd0) & ~pipe_hold & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_pend[i] <= 1'b0;
        r_cnt[i]  <= '0;
        r_age[i]  <= '0;
      end
    end else if (!pipe_hold) begin
      // Register 0 is never loaded, so its entry stays clear after reset.
      for (int i = 1; i < 32; i++) begin
        if (w_issue_load && (issue_rd == 5'(i))) begin
          r_pend[i] <= 1'b1;
          r_cnt[i]  <= issue_lat;
          r_age[i]  <= AGE_W'(1);
        end else if (r_pend[i]) begin
          if ((flush && (r_age[i] <= flush_age)) || (wb_valid && (wb_rd == 5'(i)))) begin
            r_pend[i] <= 1'b0;
            r_cnt[i]  <= '0;
            r_age[i]  <= '0;
          end else begin
            if (r_cnt[i] != '0)
              r_cnt[i] <= r_cnt[i] - 1'b1;
            if (r_age[i] != AGE_W'(NSTAGE))
              r_age[i] <= r_age[i] + 1'b1;
          end
        end
      end
    end
  end

  assign w_rs_wait  = id_rs_used & (id_rs != 5'd0) & r_pend[id_rs] & (r_cnt[id_rs] != '0);
  assign w_rt_wait  = id_rt_used & (id_rt != 5'd0) & r_pend[id_rt] & (r_cnt[id_rt] != '0);
  assign w_rs_ready = (id_rs != 5'd0) & r_pend[id_rs] & (r_cnt[id_rs] == '0);
  assign w_rt_ready = (id_rt != 5'd0) & r_pend[id_rt] & (r_cnt[id_rt] == '0);

  // Outputs are masked while rst is high so they are quiet even before the first reset edge.
  assign data_stall = ~rst & id_valid & (w_rs_wait | w_rt_wait);
  assign rs_fwd     = (~rst & w_rs_ready) ? r_age[id_rs] : '0;
  assign rt_fwd     = (~rst & w_rt_ready) ? r_age[id_rt] : '0;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (data_stall && !pipe_hold && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter NSTAGE, default 4: number of bypassable stages after ID; age codes 1=EX, 2=MEM1, 3=MEM2, 4=WB.
REQ-002 SHALL provide parameter LAT_W, default 3: width of the per-register latency countdown.
REQ-003 SHALL derive local AGE_W = clog2(NSTAGE+1).
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs, id_rt  in  5  ID source register numbers.
- id_rs_used, id_rt_used  in  1  the source is actually read.
- issue  in  1  the ID instruction advances to EX this cycle.
- issue_wr  in  1  the issuing instruction writes the register file.
- issue_rd  in  5  destination of the issuing instruction.
- issue_lat  in  LAT_W  cycles after issue before the result is bypassable (0 = ALU, 2 = load).
- pipe_hold  in  1  whole-pipe freeze; counters and ages hold.
- flush  in  1  exception/eret flush.
- flush_age  in  AGE_W  entries with age <= flush_age are discarded.
- wb_valid  in  1  write-back retiring this cycle.
- wb_rd  in  5  write-back destination.
- data_stall  out  1  ID must hold.
- rs_fwd, rt_fwd  out  AGE_W  bypass source stage; 0 = register file.
- stall_cnt  out  32  performance counter.

Function
REQ-005 SHALL keep one entry per register 1..31: pending (1 bit), cnt (LAT_W bits), age (AGE_W bits); register $0 SHALL never be pending.
REQ-006 On issue & issue_wr & issue_rd!=0 & ~pipe_hold & ~flush, the entry for issue_rd SHALL load pending=1, cnt=issue_lat, age=1, overriding any older entry for the same register.
REQ-007 Each cycle with ~pipe_hold, every other pending entry SHALL decrement cnt, saturating at 0, and increment age, saturating at NSTAGE.
REQ-008 With pipe_hold=1, all entries SHALL hold, and issue SHALL be ignored.
REQ-009 On wb_valid, the entry for wb_rd SHALL clear pending; a same-cycle issue to the same register SHALL win.
REQ-010 On flush, all entries with age <= flush_age SHALL clear, and a same-cycle issue SHALL be dropped; older entries SHALL continue to age.
REQ-011 Lookups SHALL use registered state only, so an update made this cycle becomes visible next cycle.
REQ-012 rs_wait SHALL equal id_rs_used & id_rs!=0 & pending[id_rs] & cnt[id_rs]!=0; rt_wait SHALL be the same expression using the rt signals.
REQ-013 data_stall SHALL equal id_valid & (rs_wait | rt_wait) and SHALL be combinational from the registered state.
REQ-014 rs_fwd SHALL equal age[id_rs] when pending[id_rs] & cnt[id_rs]==0 & id_rs!=0, else 0; rt_fwd SHALL be the same expression using rt.
REQ-015 The youngest writer SHALL always be the one tracked, with no duplicates, so bypass priority is implicit.

Reset
REQ-016 While rst=1 at a clock edge, all pending, cnt and age fields, and stall_cnt, SHALL clear to 0.
REQ-017 During reset, data_stall=0 and rs_fwd=rt_fwd=0.
REQ-018 Reset SHALL override issue, flush and wb_valid on the same edge.

Configuration
REQ-019 With HAZ_PERF_CNT_EN defined, stall_cnt SHALL increment on each edge where data_stall & ~pipe_hold, saturating at 32'hFFFFFFFF.
REQ-020 Without HAZ_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL be instantiated.

Verification
REQ-021 Load-use: issue rd=5 with lat=2, then id_rs=5 used. Required: data_stall=1 for 2 cycles, then 0 with rs_fwd=3 (MEM2).
REQ-022 ALU chain: issue rd=7 with lat=0. Required: next cycle id_rt=7 gives data_stall=0, rt_fwd=1 (EX); the following cycle gives rt_fwd=2.
REQ-023 Youngest wins: issue rd=3 (lat 0), then issue rd=3 again. Required: id_rs=3 gives rs_fwd=1, not 2.
REQ-024 Hold: load rd=4 with lat=2, pipe_hold=1 for 3 cycles. Required: data_stall stays 1, cnt frozen at 2, stall_cnt unchanged.
REQ-025 Flush: entries at ages 1, 2, 3, then flush with flush_age=2. Required: only the age-3 entry survives, and a same-cycle issue is dropped.
REQ-026 $0 and retire: issue rd=0 sets no pending; wb_valid with wb_rd=9 alongside issue rd=9 leaves 9 pending, age=1.
